// File: rtl/memlibc_mbist_pkg.sv
// Shared types and constants for the memory-BIST run/status handshake sequencer.
package memlibc_mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_ABORT
  } state_t;

  localparam int SETTLE_CNT_W = 8;

  // Bit positions within the sticky status bus.
  localparam int STAT_DONE    = 0;
  localparam int STAT_FAIL    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_W       = 3;

endpackage

// File: rtl/memlibc_mbist_run_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare.
module memlibc_mbist_run_timer #(
  parameter int             W        = 8,
  parameter logic [W-1:0]   TERMINAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_term
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_term = (count == TERMINAL);

endmodule

// File: rtl/memlibc_mbist_run_handshake.sv
// Run/status handshake between the synchronized BIST run level and the BIST controller.
// Optional run timeout is enabled by defining MEMLIBC_MBIST_RUN_TIMEOUT_EN.
module memlibc_mbist_run_handshake
  import memlibc_mbist_pkg::*;
#(
  parameter int          SETTLE_CYCLES  = 2,
  parameter int          TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic run_sync,
  input  logic bist_busy,
  input  logic bist_done,
  input  logic bist_fail,
  output logic mem_bist_sel,
  output logic bist_start,
  output logic bist_abort,
  output logic done_status,
  output logic fail_status,
  output logic timeout_status,
  output logic idle
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255) || (TIMEOUT_CYCLES < 1) ||
      (longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_W))) begin : g_bad_cfg
    $error("memlibc_mbist_run_handshake: illegal SETTLE_CYCLES/TIMEOUT_CYCLES");
  end

  state_t              state, next_state;
  logic                run_q;
  logic                rise;
  logic                settle_term;
  logic                run_timeout;
  logic [STAT_W-1:0]   status;

  assign rise = run_sync && !run_q;

  memlibc_mbist_run_timer #(
    .W        (SETTLE_CNT_W),
    .TERMINAL (SETTLE_CNT_W'(SETTLE_CYCLES - 1))
  ) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .inc     (state == ST_SETTLE),
    .at_term (settle_term)
  );

`ifdef MEMLIBC_MBIST_RUN_TIMEOUT_EN
  memlibc_mbist_run_timer #(
    .W        (TIMEOUT_W),
    .TERMINAL (TIMEOUT_W'(TIMEOUT_CYCLES - 1))
  ) u_run_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_START),
    .inc     (state == ST_RUN),
    .at_term (run_timeout)
  );
`else
  assign run_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      run_q <= 1'b0;
    end else begin
      state <= next_state;
      run_q <= run_sync;
    end
  end

  // NOTE: next_state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (rise) next_state = ST_SETTLE;
      ST_SETTLE: begin
        if (!run_sync)        next_state = ST_ABORT;
        else if (settle_term) next_state = ST_START;
      end
      ST_START:  next_state = ST_RUN;
      ST_RUN: begin
        // Completion wins over timeout, which wins over a dropped run level.
        if (bist_done)        next_state = ST_DONE;
        else if (run_timeout) next_state = ST_DONE;
        else if (!run_sync)   next_state = ST_ABORT;
      end
      ST_DONE:   if (!run_sync)  next_state = ST_IDLE;
      ST_ABORT:  if (!bist_busy) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Sticky status: cleared only by a new run, written at most once per run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= '0;
    end else if ((state == ST_IDLE) && rise) begin
      status <= '0;
    end else if (state == ST_RUN) begin
      if (bist_done) begin
        status[STAT_DONE] <= 1'b1;
        status[STAT_FAIL] <= bist_fail;
      end else if (run_timeout) begin
        status <= '1;
      end
    end
  end

  assign mem_bist_sel   = (state != ST_IDLE);
  assign bist_start     = (state == ST_START);
  assign bist_abort     = (state == ST_ABORT);
  assign idle           = (state == ST_IDLE);
  assign done_status    = status[STAT_DONE];
  assign fail_status    = status[STAT_FAIL];
  assign timeout_status = status[STAT_TIMEOUT];

endmodule

// File: tb/tb_memlibc_mbist_run_handshake.sv
// Randomized self-checking bench; reference model tracks run phases by remaining/elapsed cycle counts.
module tb_memlibc_mbist_run_handshake;

  localparam int SETTLE_CYCLES  = 2;
  localparam int TIMEOUT_W      = 16;
  localparam int TIMEOUT_CYCLES = 8;
`ifdef MEMLIBC_MBIST_RUN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int P_IDLE   = 0;
  localparam int P_SETTLE = 1;
  localparam int P_START  = 2;
  localparam int P_RUN    = 3;
  localparam int P_DONE   = 4;
  localparam int P_ABORT  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run_sync = 1'b0, bist_busy = 1'b0, bist_done = 1'b0, bist_fail = 1'b0;
  logic mem_bist_sel, bist_start, bist_abort, done_status, fail_status, timeout_status, idle;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int phase;
  int settle_left;
  int run_cycles;
  bit prev_run;
  bit e_done, e_fail, e_to;

  always #5 clk = ~clk;

  memlibc_mbist_run_handshake #(
    .SETTLE_CYCLES  (SETTLE_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run_sync       (run_sync),
    .bist_busy      (bist_busy),
    .bist_done      (bist_done),
    .bist_fail      (bist_fail),
    .mem_bist_sel   (mem_bist_sel),
    .bist_start     (bist_start),
    .bist_abort     (bist_abort),
    .done_status    (done_status),
    .fail_status    (fail_status),
    .timeout_status (timeout_status),
    .idle           (idle)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = P_IDLE;
    settle_left = 0;
    run_cycles = 0;
    prev_run = 1'b0;
    e_done = 1'b0;
    e_fail = 1'b0;
    e_to = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit rose;
    rose = run_sync && !prev_run;
    prev_run = run_sync;
    case (phase)
      P_IDLE: if (rose) begin
        phase = P_SETTLE;
        settle_left = SETTLE_CYCLES;
        e_done = 0; e_fail = 0; e_to = 0;
      end
      P_SETTLE: begin
        if (!run_sync) phase = P_ABORT;
        else begin
          settle_left--;
          if (settle_left == 0) phase = P_START;
        end
      end
      P_START: begin
        phase = P_RUN;
        run_cycles = 0;
      end
      P_RUN: begin
        run_cycles++;
        if (bist_done) begin
          phase = P_DONE; e_done = 1; e_fail = bist_fail;
        end else if (TO_EN && run_cycles == TIMEOUT_CYCLES) begin
          phase = P_DONE; e_done = 1; e_fail = 1; e_to = 1;
        end else if (!run_sync) begin
          phase = P_ABORT;
        end
      end
      P_DONE:  if (!run_sync)  phase = P_IDLE;
      P_ABORT: if (!bist_busy) phase = P_IDLE;
      default: phase = P_IDLE;
    endcase
  endtask

  task automatic check_outputs();
    check("mem_bist_sel",   mem_bist_sel,   phase != P_IDLE);
    check("bist_start",     bist_start,     phase == P_START);
    check("bist_abort",     bist_abort,     phase == P_ABORT);
    check("idle",           idle,           phase == P_IDLE);
    check("done_status",    done_status,    e_done);
    check("fail_status",    fail_status,    e_fail);
    check("timeout_status", timeout_status, e_to);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic r, input logic b, input logic d, input logic f);
    run_sync = r; bist_busy = b; bist_done = d; bist_fail = f;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic go_idle();
    for (int i = 0; i < 20 && phase != P_IDLE; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reach_idle", phase == P_IDLE, 1'b1);
  endtask

  task automatic reach_run();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && phase != P_RUN; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("reach_run", phase == P_RUN, 1'b1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Normal pass, done ten cycles after start, then drop.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    reach_run();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    go_idle();

    // Failing run; the next rise clears status.
    reach_run();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    go_idle();

    // Drop during settle, with the controller busy for five cycles.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    go_idle();

    // Drop during run, busy for five cycles.
    reach_run();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    go_idle();

    // Done, terminal count and drop all in the same cycle.
    reach_run();
    for (int i = 0; i < 20 && run_cycles < TIMEOUT_CYCLES - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    go_idle();

    // Randomized traffic with phase-dependent event rates.
    for (int i = 0; i < 3000; i++) begin
      logic r, b, d, f;
      r = run_sync;
      case (phase)
        P_IDLE:   if ($urandom_range(3) == 0)  r = ~run_sync;
        P_SETTLE: if ($urandom_range(15) == 0) r = 1'b0;
        P_RUN:    if ($urandom_range(39) == 0) r = 1'b0;
        P_DONE:   if ($urandom_range(3) == 0)  r = 1'b0;
        P_ABORT:  if ($urandom_range(7) == 0)  r = ~run_sync;
        default:  ;
      endcase
      b = ($urandom_range(2) != 0);
      d = (phase == P_RUN) ? ($urandom_range(11) == 0) : ($urandom_range(19) == 0);
      f = $urandom_range(1) != 0;
      step(r, b, d, f);
    end

    // Asynchronous reset in the middle of a run.
    go_idle();
    reach_run();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    run_sync = 1'b0;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
